// File: rtl/fp_mul_issue_ctrl_pkg.sv
// Shared types for the FP multiplier issue controller: rounding modes,
// request/result records and the rounding-mode legality helper.
package fp_mul_issue_ctrl_pkg;

   localparam int unsigned FP_MUL_TAG_W = 5;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100,
      DYN = 3'b111
   } fp_rm_e;

   // rm is kept as a raw field: illegal encodings must be representable.
   typedef struct packed {
      logic [31:0]             a;
      logic [31:0]             b;
      logic [2:0]              rm;
      logic [FP_MUL_TAG_W-1:0] tag;
   } fp_mul_req_t;

   typedef struct packed {
      logic [31:0]             data;
      logic [FP_MUL_TAG_W-1:0] tag;
      logic                    src;
      logic                    illegal;
   } fp_mul_res_t;

   // A resolved rounding mode is legal only for RNE..RMM.
   function automatic logic fp_rm_legal(input logic [2:0] rm);
      return rm <= 3'(RMM);
   endfunction

endpackage

// File: rtl/fp_mul_issue_ctrl_if.sv
// Issue-side request bus (two requesters) and writeback-side result bus.
interface fp_mul_issue_ctrl_if #(
   parameter int unsigned TAG_W = 5
);
   logic [1:0]            req_valid;
   logic [1:0][31:0]      req_a;
   logic [1:0][31:0]      req_b;
   logic [1:0][2:0]       req_rm;
   logic [1:0][TAG_W-1:0] req_tag;
   logic [1:0]            req_ready;

   logic                  res_valid;
   logic                  res_ready;
   logic [31:0]           res_data;
   logic [TAG_W-1:0]      res_tag;
   logic                  res_src;
   logic                  res_illegal;

   // Issue logic and writeback side
   modport master (
      output req_valid, req_a, req_b, req_rm, req_tag, res_ready,
      input  req_ready, res_valid, res_data, res_tag, res_src, res_illegal
   );

   // Issue controller side
   modport slave (
      input  req_valid, req_a, req_b, req_rm, req_tag, res_ready,
      output req_ready, res_valid, res_data, res_tag, res_src, res_illegal
   );
endinterface

// File: rtl/fp_mul_res_fifo.sv
// Small result FIFO between the multiplier and writeback. Flush and reset
// empty it; reset also zeroes storage so the head reads as 0 afterwards.
module fp_mul_res_fifo #(
   parameter  int unsigned DEPTH = 2,
   parameter  int unsigned W     = 32,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head_data,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Next-state for storage, pointers and count; flush wins over push/pop
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = cnt_q;

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Shares one single-stage FP multiplier between two issue requesters:
// round-robin grant, dynamic rounding-mode resolution, an s1 stage that
// tracks the op whose result appears next cycle, and a result FIFO so
// writeback stalls never drop an in-flight op. TAG_W must equal
// FP_MUL_TAG_W because the result record is a package type.
module fp_mul_issue_ctrl
   import fp_mul_issue_ctrl_pkg::*;
#(
   parameter int unsigned TAG_W = FP_MUL_TAG_W,
   parameter int unsigned DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [2:0]          frm,
   fp_mul_issue_ctrl_if.slave  io,
   output logic                mul_en,
   output logic                mul_clear,
   output logic [31:0]         mul_a,
   output logic [31:0]         mul_b,
   output logic [2:0]          mul_rm,
   output logic                mul_p,
   input  logic [31:0]         mul_result
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             pop;
   logic             can_issue;
   logic             fire;
   logic             winner;
   logic [CNT_W:0]   occ;
   logic [2:0]       rm_eff;
   logic             rm_ok;
   fp_mul_req_t      win_req;
   fp_mul_res_t      push_res;
   fp_mul_res_t      head_res;
   logic [CNT_W-1:0] fifo_count;

   logic             s1_v_q, s1_v_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic             s1_src_q, s1_src_d;
   logic             s1_ill_q, s1_ill_d;
   logic             rr_ptr_q, rr_ptr_d;

   // Arbitration, grant and multiplier drive for the current cycle
   always_comb begin
      pop = io.res_valid & io.res_ready;
      // Occupancy after this cycle: FIFO plus the s1 op that lands next edge.
      occ = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(s1_v_q) - (CNT_W + 1)'(pop);
      can_issue = rst & ~flush & (occ < (CNT_W + 1)'(DEPTH));
      winner = (&io.req_valid) ? rr_ptr_q : io.req_valid[1];
      fire = can_issue & (|io.req_valid);

      io.req_ready = '0;
      if (fire) begin
         io.req_ready[winner] = 1'b1;
      end

      win_req.a   = io.req_a[winner];
      win_req.b   = io.req_b[winner];
      win_req.rm  = io.req_rm[winner];
      win_req.tag = io.req_tag[winner];

      rm_eff = (win_req.rm == 3'(DYN)) ? frm : win_req.rm;
      rm_ok  = fp_rm_legal(rm_eff);

      mul_en    = fire;
      mul_p     = fire;
      mul_clear = ~rst | flush;
      mul_a     = fire ? win_req.a : '0;
      mul_b     = fire ? win_req.b : '0;
      mul_rm    = (fire && rm_ok) ? rm_eff : 3'(RNE);
   end

   // Next-state for the s1 tracking stage and round-robin pointer
   always_comb begin
      s1_v_d   = fire;
      s1_tag_d = s1_tag_q;
      s1_src_d = s1_src_q;
      s1_ill_d = s1_ill_q;
      rr_ptr_d = rr_ptr_q;
      if (fire) begin
         s1_tag_d = win_req.tag;
         s1_src_d = winner;
         s1_ill_d = ~rm_ok;
         rr_ptr_d = ~winner;
      end
   end

   // s1 stage and arbiter state registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_v_q   <= 1'b0;
         s1_tag_q <= '0;
         s1_src_q <= 1'b0;
         s1_ill_q <= 1'b0;
         rr_ptr_q <= 1'b0;
      end else begin
         s1_v_q   <= s1_v_d;
         s1_tag_q <= s1_tag_d;
         s1_src_q <= s1_src_d;
         s1_ill_q <= s1_ill_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign push_res = '{data: mul_result, tag: s1_tag_q, src: s1_src_q, illegal: s1_ill_q};

   fp_mul_res_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fp_mul_res_t))
   ) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (s1_v_q),
      .push_data (push_res),
      .pop       (pop),
      .head_data (head_res),
      .count     (fifo_count)
   );

   assign io.res_valid   = (fifo_count != '0);
   assign io.res_data    = head_res.data;
   assign io.res_tag     = head_res.tag;
   assign io.res_src     = head_res.src;
   assign io.res_illegal = head_res.illegal;

   // The issue condition reserves a slot for the s1 op, so this never trips.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      ((CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(s1_v_q) <= (CNT_W + 1)'(DEPTH)));

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Directed bench for fp_mul_issue_ctrl with a behavioural single-stage
// multiplier: operands registered on en, result combinational from them.
module tb_fp_mul_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [2:0]  frm;
   logic        mul_en, mul_clear, mul_p;
   logic [31:0] mul_a, mul_b, mul_result;
   logic [2:0]  mul_rm;
   logic [31:0] ma_q, mb_q;

   int checks = 0;
   int errors = 0;

   fp_mul_issue_ctrl_if #(.TAG_W(5)) bus ();

   fp_mul_issue_ctrl #(.TAG_W(5), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .frm        (frm),
      .io         (bus),
      .mul_en     (mul_en),
      .mul_clear  (mul_clear),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_rm     (mul_rm),
      .mul_p      (mul_p),
      .mul_result (mul_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Known IEEE products; any other operand pair uses a+b as a distinct stand-in.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
      if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return 32'h4010_0000;
      return a + b;
   endfunction

   always_ff @(posedge clk) begin
      if (mul_clear) begin
         ma_q <= '0;
         mb_q <= '0;
      end else if (mul_en) begin
         ma_q <= mul_a;
         mb_q <= mul_b;
      end
   end

   always_comb mul_result = fmul(ma_q, mb_q);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] rm0, input logic [4:0] t0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] rm1, input logic [4:0] t1);
      bus.req_valid  = v;
      bus.req_a[0]   = a0;
      bus.req_b[0]   = b0;
      bus.req_rm[0]  = rm0;
      bus.req_tag[0] = t0;
      bus.req_a[1]   = a1;
      bus.req_b[1]   = b1;
      bus.req_rm[1]  = rm1;
      bus.req_tag[1] = t1;
   endtask

   task automatic idle();
      drive(2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      tick();
      rst = 1'b1;
   endtask

   // One op from one requester, checked at issue and two cycles later.
   task automatic run_single(input logic src, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] rm, input logic [2:0] f, input logic [4:0] tag,
                             input logic [2:0] exp_rm, input logic [31:0] exp_data, input logic exp_ill);
      frm = f;
      if (src) drive(2'b10, '0, '0, '0, '0, a, b, rm, tag);
      else     drive(2'b01, a, b, rm, tag, '0, '0, '0, '0);
      #1;
      check("single_ready", 32'(bus.req_ready), src ? 32'd2 : 32'd1);
      check("single_mul_rm", 32'(mul_rm), 32'(exp_rm));
      check("single_mul_en", 32'(mul_en), 32'd1);
      tick();
      idle();
      #1;
      check("single_lat_c1", 32'(bus.res_valid), 32'd0);
      tick();
      check("single_valid", 32'(bus.res_valid), 32'd1);
      check("single_data", bus.res_data, exp_data);
      check("single_tag", 32'(bus.res_tag), 32'(tag));
      check("single_src", 32'(bus.res_src), 32'(src));
      check("single_ill", 32'(bus.res_illegal), 32'(exp_ill));
      tick();
      check("single_drained", 32'(bus.res_valid), 32'd0);
   endtask

   int          bp_ready [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
   int          bp_req   [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
   int          bp_tag   [11] = '{20, 21, 22, 22, 22, 22, 23, 24, 0, 0, 0};
   int          bp_grant [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
   int          bp_rv    [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   int          bp_head  [11] = '{0, 0, 20, 20, 20, 20, 21, 22, 23, 24, 0};

   initial begin
      rst           = 1'b0;
      flush         = 1'b0;
      frm           = 3'b000;
      bus.res_ready = 1'b1;
      idle();

      // Reset state
      tick();
      tick();
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_res_data", bus.res_data, 32'd0);
      check("rst_res_tag", 32'(bus.res_tag), 32'd0);
      check("rst_mul_en", 32'(mul_en), 32'd0);
      check("rst_mul_clear", 32'(mul_clear), 32'd1);
      rst = 1'b1;
      #1;
      check("run_mul_clear", 32'(mul_clear), 32'd0);
      check("idle_mul_a", mul_a, 32'd0);

      // 2.0 x 3.0 from requester 0
      run_single(1'b0, 32'h4000_0000, 32'h4040_0000, 3'b000, 3'b000, 5'd3, 3'b000, 32'h40C0_0000, 1'b0);

      // Dual requests from rr_ptr=0: grants alternate, results follow in order
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c < 4) drive(2'b11, 32'(c * 16), 32'h100, 3'b000, 5'(8 + c),
                          32'(c * 16 + 1), 32'h200, 3'b000, 5'(16 + c));
         else       idle();
         #1;
         if (c < 4) check("rr_grant", 32'(bus.req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
         if (c >= 2) begin
            check("rr_valid", 32'(bus.res_valid), 32'd1);
            check("rr_src", 32'(bus.res_src), 32'((c - 2) % 2));
            check("rr_tag", 32'(bus.res_tag), ((c - 2) % 2 == 0) ? 32'(8 + c - 2) : 32'(16 + c - 2));
            check("rr_data", bus.res_data, ((c - 2) % 2 == 0) ? 32'((c - 2) * 16 + 32'h100)
                                                              : 32'((c - 2) * 16 + 1 + 32'h200));
         end
         tick();
      end

      // Writeback backpressure with requester 0 streaming
      do_reset();
      for (int c = 0; c < 11; c++) begin
         bus.res_ready = (bp_ready[c] != 0);
         if (bp_req[c] != 0) drive(2'b01, 32'(bp_tag[c]), 32'd0, 3'b000, 5'(bp_tag[c]), '0, '0, '0, '0);
         else                idle();
         #1;
         check("bp_grant", 32'(bus.req_ready), 32'(bp_grant[c]));
         check("bp_valid", 32'(bus.res_valid), 32'(bp_rv[c]));
         if (bp_rv[c] != 0) begin
            check("bp_tag", 32'(bus.res_tag), 32'(bp_head[c]));
            check("bp_data", bus.res_data, 32'(bp_head[c]));
         end
         tick();
      end
      bus.res_ready = 1'b1;

      // Dynamic rounding mode resolution and illegal modes
      run_single(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 3'b111, 3'b001, 5'd7, 3'b001, 32'h4010_0000, 1'b0);
      run_single(1'b1, 32'h0000_0010, 32'h0000_0020, 3'b111, 3'b101, 5'd9, 3'b000, 32'h0000_0030, 1'b1);
      run_single(1'b0, 32'h0000_0001, 32'h0000_0002, 3'b110, 3'b000, 5'd11, 3'b000, 32'h0000_0003, 1'b1);
      run_single(1'b0, 32'h0000_0004, 32'h0000_0005, 3'b010, 3'b101, 5'd12, 3'b010, 32'h0000_0009, 1'b0);

      // Flush with one op in the FIFO and one in s1
      bus.res_ready = 1'b0;
      drive(2'b01, 32'h11, 32'h0, 3'b000, 5'd1, '0, '0, '0, '0);
      tick();
      drive(2'b01, 32'h12, 32'h0, 3'b000, 5'd2, '0, '0, '0, '0);
      tick();
      flush         = 1'b1;
      bus.res_ready = 1'b1;
      drive(2'b01, 32'h13, 32'h0, 3'b000, 5'd3, '0, '0, '0, '0);
      #1;
      check("fl_head_before", 32'(bus.res_tag), 32'd1);
      check("fl_ready", 32'(bus.req_ready), 32'd0);
      check("fl_mul_clear", 32'(mul_clear), 32'd1);
      check("fl_mul_en", 32'(mul_en), 32'd0);
      tick();
      flush = 1'b0;
      idle();
      for (int c = 0; c < 3; c++) begin
         #1;
         check("fl_no_result", 32'(bus.res_valid), 32'd0);
         tick();
      end

      // Reset while the FIFO holds two entries
      bus.res_ready = 1'b0;
      drive(2'b01, 32'h4, 32'h0, 3'b000, 5'd4, '0, '0, '0, '0);
      tick();
      drive(2'b01, 32'h5, 32'h0, 3'b000, 5'd5, '0, '0, '0, '0);
      tick();
      idle();
      tick();
      check("mr_full_head", 32'(bus.res_tag), 32'd4);
      rst = 1'b0;
      drive(2'b11, 32'h6, 32'h0, 3'b000, 5'd6, 32'h7, 32'h0, 3'b000, 5'd7);
      #1;
      check("mr_ready", 32'(bus.req_ready), 32'd0);
      check("mr_mul_clear", 32'(mul_clear), 32'd1);
      check("mr_mul_a", mul_a, 32'd0);
      tick();
      rst = 1'b1;
      #1;
      check("mr_res_valid", 32'(bus.res_valid), 32'd0);
      check("mr_res_data", bus.res_data, 32'd0);
      check("mr_res_tag", 32'(bus.res_tag), 32'd0);
      check("mr_res_src", 32'(bus.res_src), 32'd0);
      check("mr_res_ill", 32'(bus.res_illegal), 32'd0);
      check("mr_first_grant", 32'(bus.req_ready), 32'd1);
      tick();
      check("mr_second_grant", 32'(bus.req_ready), 32'd2);
      idle();
      bus.res_ready = 1'b1;
      tick();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
